// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one-hot grant for the channel mux,
// held from address handshake through the final data/response handshake.
module bus_arbiter #(
    parameter int CHANNEL = 2,
    localparam int GW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CHANNEL-1:0] req,
    input  logic               addr_hs,
    input  logic               last_hs,
    output logic [CHANNEL-1:0] sel,
    output logic [GW-1:0]      grant_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [GW-1:0]      ptr, ptr_n;
    logic [CHANNEL-1:0] sel_n;
    logic [GW-1:0]      gid_n;
    logic               busy_n;

    logic               pick_vld;
    logic [GW-1:0]      pick;
    logic [GW-1:0]      ptr_adv;

    // First requesting master at or above ptr, wrapping modulo CHANNEL.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < CHANNEL; i++) begin
            idx = int'(ptr) + i;
            if (idx >= CHANNEL)
                idx = idx - CHANNEL;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = GW'(idx);
            end
        end
    end

    // Served master drops to lowest priority on release.
    always_comb begin
        if (grant_id == GW'(CHANNEL - 1))
            ptr_adv = '0;
        else
            ptr_adv = grant_id + GW'(1);
    end

    // Next-state and registered-output values.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        gid_n   = grant_id;
        busy_n  = busy;
        unique case (state)
            IDLE: begin
                sel_n  = '0;
                gid_n  = '0;
                busy_n = 1'b0;
                if (pick_vld) begin
                    state_n     = ADDR;
                    sel_n[pick] = 1'b1;
                    gid_n       = pick;
                    busy_n      = 1'b1;
                end
            end
            ADDR: begin
                if (addr_hs) begin
                    if (last_hs) begin
                        state_n = IDLE;
                        ptr_n   = ptr_adv;
                        sel_n   = '0;
                        gid_n   = '0;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (last_hs) begin
                    state_n = IDLE;
                    ptr_n   = ptr_adv;
                    sel_n   = '0;
                    gid_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = '0;
                gid_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            grant_id <= gid_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (CHANNEL = 2).
// Outputs are sampled 1 time unit after each rising edge.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic       addr_hs;
    logic       last_hs;
    logic [1:0] sel;
    logic [0:0] grant_id;
    logic       busy;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.CHANNEL(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr_hs  (addr_hs),
        .last_hs  (last_hs),
        .sel      (sel),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] e_sel,
                              input logic e_gid, input logic e_busy);
        chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
        chk({tag, ".gid"}, 32'(grant_id), 32'(e_gid));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        logic [1:0] rr_exp [4];
        rr_exp[0] = 2'b01;
        rr_exp[1] = 2'b10;
        rr_exp[2] = 2'b01;
        rr_exp[3] = 2'b10;

        rst = 1'b1; req = 2'b11; addr_hs = 1'b0; last_hs = 1'b0;
        tick();
        tick();
        expect_out("reset", 2'b00, 1'b0, 1'b0);

        rst = 1'b0;
        tick();
        expect_out("first_grant", 2'b01, 1'b0, 1'b1);

        addr_hs = 1'b1; last_hs = 1'b1;
        tick();
        expect_out("simul_hs_idle", 2'b00, 1'b0, 1'b0);

        addr_hs = 1'b0; last_hs = 1'b0;
        tick();
        expect_out("ptr_advanced", 2'b10, 1'b1, 1'b1);

        req = 2'b00; addr_hs = 1'b1;
        tick();
        expect_out("data_hold", 2'b10, 1'b1, 1'b1);

        addr_hs = 1'b0; last_hs = 1'b1;
        tick();
        expect_out("release", 2'b00, 1'b0, 1'b0);

        addr_hs = 1'b1; last_hs = 1'b1;
        tick();
        expect_out("stray_hs_idle", 2'b00, 1'b0, 1'b0);

        addr_hs = 1'b0; last_hs = 1'b0; req = 2'b10;
        tick();
        expect_out("single_grant", 2'b10, 1'b1, 1'b1);
        tick();
        addr_hs = 1'b1;
        tick();
        expect_out("single_addr", 2'b10, 1'b1, 1'b1);
        addr_hs = 1'b0;
        tick();
        tick();
        expect_out("single_data", 2'b10, 1'b1, 1'b1);
        last_hs = 1'b1;
        tick();
        expect_out("single_release", 2'b00, 1'b0, 1'b0);
        last_hs = 1'b0;

        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out($sformatf("rr_grant%0d", i), rr_exp[i],
                       rr_exp[i][1], 1'b1);
            addr_hs = 1'b1;
            tick();
            addr_hs = 1'b0;
            tick();
            expect_out($sformatf("rr_data%0d", i), rr_exp[i],
                       rr_exp[i][1], 1'b1);
            last_hs = 1'b1;
            tick();
            last_hs = 1'b0;
            expect_out($sformatf("rr_bubble%0d", i), 2'b00, 1'b0, 1'b0);
        end

        req = 2'b01;
        tick();
        expect_out("hold_grant", 2'b01, 1'b0, 1'b1);
        req = 2'b10;
        tick();
        expect_out("hold_req_drop", 2'b01, 1'b0, 1'b1);
        tick();
        expect_out("hold_req_drop2", 2'b01, 1'b0, 1'b1);
        addr_hs = 1'b1;
        tick();
        expect_out("hold_addr", 2'b01, 1'b0, 1'b1);
        addr_hs = 1'b0; last_hs = 1'b1;
        tick();
        expect_out("hold_release", 2'b00, 1'b0, 1'b0);
        last_hs = 1'b0;
        tick();
        expect_out("hold_next", 2'b10, 1'b1, 1'b1);

        addr_hs = 1'b1;
        tick();
        expect_out("pre_reset_data", 2'b10, 1'b1, 1'b1);
        addr_hs = 1'b0; rst = 1'b1;
        tick();
        expect_out("mid_reset", 2'b00, 1'b0, 1'b0);
        rst = 1'b0; req = 2'b11;
        tick();
        expect_out("post_reset_grant", 2'b01, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that produces the one-hot `sel` vector for the bus channel multiplexer, directly upstream of it. Samples per-master request lines, grants exactly one master, and holds the grant from address handshake through the final data/response handshake so the return path routes to the same master. Used once per AXI direction: read (AR + R) and write (AW + W + B).

## Interface
- `CHANNEL`, 2: number of masters; one `req` bit and one `sel` bit per master.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `req`  input  CHANNEL  per-master request, i.e. that master's address VALID.
- `addr_hs`  input  1  address handshake (VALID & READY) of the granted master this cycle.
- `last_hs`  input  1  final handshake of the transaction this cycle: RLAST beat, or B response.
- `sel`  output  CHANNEL  one-hot grant to the mux; all-zero when no grant.
- `grant_id`  output  $clog2(CHANNEL), min 1  binary index of the set `sel` bit; 0 when `sel` is zero.
- `busy`  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ADDR, DATA. All outputs are registered.
- IDLE:
  - `sel` = 0.
  - If any `req` bit is set, choose the first set bit starting at priority pointer `ptr` and wrapping upward modulo CHANNEL.
  - Load `sel` and `grant_id` for the chosen master and go to ADDR.
- ADDR:
  - `sel` held constant.
  - On `addr_hs`: go to DATA; if `last_hs` is also high that cycle, go to IDLE instead.
  - Dropping `req` has no effect; the grant is held until the handshakes.
- DATA:
  - `sel` held constant.
  - On `last_hs`: go to IDLE and clear `sel`.
  - `addr_hs` is ignored.
- Pointer update: on the exit to IDLE, `ptr` = (granted index + 1) mod CHANNEL. The last-served master becomes lowest priority.
- `addr_hs` and `last_hs` are ignored in IDLE.
- Reset values: state IDLE, `ptr` 0 (master 0 highest), `sel` 0, `grant_id` 0, `busy` 0.
- Reset asserted mid-transaction: abandon the grant, return to reset values next edge; no completion required.
- Invariant: `sel` is zero or exactly one-hot at every cycle, and `sel` is constant between grant and release.

## Timing
- `req` sampled high at edge n (IDLE): `sel`/`busy` valid after edge n, i.e. 1-cycle grant latency.
- `addr_hs` at edge m in ADDR: still granted through DATA.
- `last_hs` at edge k: `sel` = 0 and `busy` = 0 after edge k.
- At least one IDLE cycle between consecutive grants. Back-to-back transactions cost 1 bubble cycle.
- Minimum transaction occupancy: 1 cycle in ADDR (simultaneous `addr_hs` + `last_hs`).
- No combinational path from any input to any output.

## Test plan
- Reset: hold `rst` 2 cycles with `req`=2'b11 → `sel`=0, `busy`=0, `grant_id`=0. After release, first grant goes to master 0 (`sel`=2'b01).
- Single master: `req`=2'b10 at edge 1 → `sel`=2'b10 and `grant_id`=1 after edge 1. `addr_hs` at edge 3 → `sel` still 2'b10. `last_hs` at edge 6 → `sel`=0 after edge 6.
- Round robin: `req`=2'b11 held, each transaction done with `addr_hs` then `last_hs` 2 cycles later → grants alternate 01, 10, 01, 10, with one IDLE cycle between each.
- Grant hold: granted master 0 deasserts `req` in ADDR while master 1 requests → `sel` stays 2'b01 until `addr_hs` and `last_hs`; master 1 is granted only afterwards.
- Simultaneous events: `addr_hs` and `last_hs` in the same ADDR cycle → IDLE next cycle, `ptr` advanced. A stray `last_hs` in IDLE → no state change.
- Reset mid-DATA with master 1 granted → `sel`=0 after the reset edge, `ptr`=0, next `req`=2'b11 grants master 0.
